// File: rtl/word_loader.sv
// Splits a character stream into zero-terminated words and writes them to a word RAM.
// The image always ends in a double zero, or a single zero for empty input.
module word_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEP_CHAR = DATA_WIDTH'(8'h20)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  overflow,
    output logic                  done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    // Two slots are held back so a word terminator plus the final zero always fit.
    localparam logic [ADDR_WIDTH-1:0] PTR_LIMIT = ADDR_WIDTH'(DEPTH - 3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        TERM_A = 3'd3,
        TERM_B = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] wc_d;
    logic                  prev_sep_q, prev_sep_d;
    logic                  ovf_d, done_d, ready_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic                  accept;
    logic                  is_sep;

    assign accept = in_valid & in_ready;
    assign is_sep = (in_data == SEP_CHAR) || (in_data == '0);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            prev_sep_q <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            prev_sep_q <= prev_sep_d;
            word_count <= wc_d;
            overflow   <= ovf_d;
            done       <= done_d;
            in_ready   <= ready_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_din    <= din_d;
        end
    end

    // Next state, pointer bookkeeping and next RAM write
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        prev_sep_d = prev_sep_q;
        wc_d       = word_count;
        ovf_d      = overflow;
        done_d     = done;
        we_d       = 1'b0;
        addr_d     = mem_addr;
        din_d      = mem_din;

        case (state_q)
            IDLE: begin
                if (cs) begin
                    state_d    = LOAD;
                    ptr_d      = '0;
                    wc_d       = '0;
                    ovf_d      = 1'b0;
                    done_d     = 1'b0;
                    prev_sep_d = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (is_sep) begin
                        if (!prev_sep_q) begin
                            we_d       = 1'b1;
                            addr_d     = ptr_q;
                            din_d      = '0;
                            ptr_d      = ptr_q + ADDR_WIDTH'(1);
                            wc_d       = word_count + ADDR_WIDTH'(1);
                            prev_sep_d = 1'b1;
                        end
                    end else if (ptr_q <= PTR_LIMIT) begin
                        we_d       = 1'b1;
                        addr_d     = ptr_q;
                        din_d      = in_data;
                        ptr_d      = ptr_q + ADDR_WIDTH'(1);
                        prev_sep_d = 1'b0;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = DRAIN;
                    end
                    if (in_last) begin
                        state_d = TERM_A;
                    end
                end
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_d = TERM_A;
                end
            end
            TERM_A: begin
                if (!prev_sep_q) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    din_d  = '0;
                    ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    wc_d   = word_count + ADDR_WIDTH'(1);
                end
                state_d = TERM_B;
            end
            TERM_B: begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                din_d   = '0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!cs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == LOAD) || (state_d == DRAIN);
    end

endmodule

// File: doc/word_loader.md
WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL be the word-RAM address width; DEPTH = 2^ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL be the character width.
REQ-003 Parameter SEP_CHAR, default 8'h20, SHALL be the word-separator character.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 cs  in  1  SHALL be the level start request.
REQ-007 in_valid  in  1  SHALL mark in_data/in_last as valid.
REQ-008 in_data  in  DATA_WIDTH  SHALL carry the raw character.
REQ-009 in_last  in  1  SHALL mark the final character of the sentence.
REQ-010 in_ready  out  1  SHALL indicate the block accepts a beat this cycle.
REQ-011 mem_we  out  1  SHALL be the word-RAM write enable.
REQ-012 mem_addr  out  ADDR_WIDTH  SHALL be the word-RAM write address.
REQ-013 mem_din  out  DATA_WIDTH  SHALL be the word-RAM write data.
REQ-014 word_count  out  ADDR_WIDTH  SHALL be the number of words written.
REQ-015 overflow  out  1  SHALL flag that the input exceeded capacity (sticky).
REQ-016 done  out  1  SHALL flag that the RAM image is complete and the encoder may start.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DRAIN, TERM_A, TERM_B, DONE.
REQ-018 IDLE: in_ready=0; cs=1 SHALL go to LOAD and clear the write pointer, word_count, overflow and done, and set prev_sep=1.
REQ-019 LOAD: in_ready SHALL be 1; a beat SHALL be accepted only when in_valid & in_ready.
REQ-020 An accepted beat with in_data==SEP_CHAR or 0 and prev_sep=0 SHALL write 0 at the pointer, increment the pointer and word_count, and set prev_sep=1.
REQ-021 An accepted separator or 0 with prev_sep=1 SHALL be dropped, with no write; leading and repeated separators therefore collapse.
REQ-022 An accepted non-separator with pointer <= DEPTH-3 SHALL write in_data at the pointer, increment the pointer and clear prev_sep.
REQ-023 An accepted non-separator with pointer > DEPTH-3 SHALL be dropped and SHALL set overflow=1; the FSM goes to DRAIN, or to TERM_A if in_last.
REQ-024 DRAIN SHALL hold in_ready=1, discard every beat without writing, and go to TERM_A on an accepted in_last.
REQ-025 An accepted beat with in_last in LOAD SHALL be processed per REQ-020 to REQ-023, then the FSM SHALL go to TERM_A.
REQ-026 TERM_A: if prev_sep=0, the block SHALL write 0, increment the pointer and word_count, and go to TERM_B; otherwise it SHALL go to TERM_B with no write.
REQ-027 TERM_B SHALL write 0 at the pointer and go to DONE; the image always ends with a double 0, or a single 0 at address 0 for empty input.
REQ-028 In TERM_A, TERM_B and DONE, in_ready SHALL be 0.
REQ-029 DONE SHALL hold done=1; cs=0 SHALL return to IDLE, and done, word_count and overflow SHALL hold until the next start.
REQ-030 mem_we, mem_addr and mem_din SHALL be registered: a write decided at edge N is presented in the cycle after edge N, for one cycle only.
REQ-031 The reserve in REQ-022 SHALL guarantee the pointer never wraps; the maximum address written is DEPTH-1.
REQ-032 A cs change outside IDLE or DONE SHALL be ignored.

Reset
REQ-033 While rst_n=0, in any state, the block SHALL enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_din=0, word_count=0, overflow=0, done=0 and prev_sep=1.
REQ-034 A reset during LOAD SHALL abort at once; RAM contents already written are not cleared.

Verification
REQ-035 The bench SHALL cover: cs=1, beats 68 69 20 79 6F 75 (last on 75) -> RAM[0..7] = 68 69 00 79 6F 75 00 00, word_count=2, done=1, overflow=0.
REQ-036 The bench SHALL cover: beats 20 20 61 20 20 62 20 (last on final 20) -> RAM[0..4] = 61 00 62 00 00, word_count=2, no write at address 5.
REQ-037 The bench SHALL cover: a single beat 20 with last -> one write, RAM[0]=00, word_count=0, done=1.
REQ-038 The bench SHALL cover: 20 beats of 41 (last on 20th) with DEPTH=16 -> RAM[0..13]=41, RAM[14]=00, RAM[15]=00, overflow=1, word_count=1, and all 20 beats accepted.
REQ-039 The bench SHALL cover: in_valid toggled 1/0 each cycle in LOAD -> RAM image identical to the REQ-035 case, and no write in cycles without an accepted beat.
REQ-040 The bench SHALL cover: rst_n=0 after the 3rd beat -> next cycle in IDLE with all outputs 0; after restart, the REQ-035 stimulus gives the REQ-035 image.
